s_div: RTL and testbench



---
 rtl/s_div.sv | 140 ++++++++++++++
 tb/tb_s_div.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/s_div.sv
// Sequential signed 32/16 divider: operands arrive on a shared 16-bit bus over three
// edges, then a 16-step restoring divide on magnitudes followed by a sign fix-up.
module s_div (
    input  logic        CLK,
    input  logic        Rst_n,
    input  logic        St,
    input  logic [15:0] Dbus,
    output logic [15:0] Quotient,
    output logic [15:0] Remainder,
    output logic        V,
    output logic        Rdy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADL = 3'd1,
        LOADD = 3'd2,
        CHECK = 3'd3,
        DIV   = 3'd4,
        FIX   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] acc_q, acc_d;
    logic [15:0] q_q, q_d;
    logic [15:0] dvs_q, dvs_d;
    logic        sign_d_q, sign_d_d;
    logic        sign_q_q, sign_q_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        v_q, v_d;

    logic [16:0] dvs_mag;
    logic [31:0] dividend_neg;
    logic [32:0] shifted;
    logic        ge;
    logic [16:0] acc_sub;

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            q_q      <= '0;
            dvs_q    <= '0;
            sign_d_q <= 1'b0;
            sign_q_q <= 1'b0;
            cnt_q    <= '0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            dvs_q    <= dvs_d;
            sign_d_q <= sign_d_d;
            sign_q_q <= sign_q_d;
            cnt_q    <= cnt_d;
            v_q      <= v_d;
        end
    end

    // 17-bit magnitude so that a divisor of 0x8000 yields 32768
    assign dvs_mag      = Dbus[15] ? (17'd0 - {1'b1, Dbus}) : {1'b0, Dbus};
    assign dividend_neg = 32'd0 - {acc_q[15:0], q_q};
    assign shifted      = {acc_q, q_q} << 1;
    assign ge           = (acc_q >= {1'b0, dvs_q});
    assign acc_sub      = acc_q - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (St) state_d = LOADL;
            LOADL:   state_d = LOADD;
            LOADD:   state_d = CHECK;
            CHECK:   state_d = (shifted[32:16] >= {1'b0, dvs_q}) ? IDLE : DIV;
            DIV:     if (cnt_q == 4'd15) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        q_d      = q_q;
        dvs_d    = dvs_q;
        sign_d_d = sign_d_q;
        sign_q_d = sign_q_q;
        cnt_d    = cnt_q;
        v_d      = v_q;
        case (state_q)
            IDLE: begin
                if (St) begin
                    acc_d    = {1'b0, Dbus};
                    sign_d_d = Dbus[15];
                    v_d      = 1'b0;
                end
            end
            LOADL: q_d = Dbus;
            LOADD: begin
                sign_q_d = sign_d_q ^ Dbus[15];
                dvs_d    = dvs_mag[15:0];
                if (sign_d_q) begin
                    acc_d = {1'b0, dividend_neg[31:16]};
                    q_d   = dividend_neg[15:0];
                end
            end
            CHECK: begin
                acc_d = shifted[32:16];
                q_d   = shifted[15:0];
                cnt_d = '0;
                if (shifted[32:16] >= {1'b0, dvs_q}) begin
                    v_d = 1'b1;
                end
            end
            DIV: begin
                // Compare/subtract fills q[0]; shift between steps but not after the last,
                // so Acc ends holding the remainder and Q all 16 quotient bits.
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    acc_d = ge ? acc_sub : acc_q;
                    q_d   = {q_q[15:1], ge};
                end else begin
                    acc_d = ge ? {acc_sub[15:0], q_q[15]} : {acc_q[15:0], q_q[15]};
                    q_d   = {q_q[14:1], ge, 1'b0};
                end
            end
            FIX: begin
                if (sign_q_q) q_d = 16'd0 - q_q;
                if (sign_d_q) acc_d[15:0] = 16'd0 - acc_q[15:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        Rdy       = (state_q == IDLE);
        Quotient  = q_q;
        Remainder = acc_q[15:0];
        V         = v_q;
    end

endmodule

// File: tb/tb_s_div.sv
// Scoreboard bench for s_div: directed operations run back-to-back, expected results queued
// at start and checked by a monitor on each Rdy rising edge, plus reset behaviour.
module tb_s_div;

    logic        CLK;
    logic        Rst_n;
    logic        St;
    logic [15:0] Dbus;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        V;
    logic        Rdy;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        v;
        int          lat;
        int          e1;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   tests;
    int   fails;

    s_div dut (
        .CLK      (CLK),
        .Rst_n    (Rst_n),
        .St       (St),
        .Dbus     (Dbus),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .V        (V),
        .Rdy      (Rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per Rdy rising edge while out of reset
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (Rst_n && Rdy && !prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_rdy", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", {16'd0, Quotient}, {16'd0, e.q});
                    check("remainder", {16'd0, Remainder}, {16'd0, e.r});
                    check("v_flag", {31'd0, V}, {31'd0, e.v});
                    check("latency", cyc - e.e1 + 1, e.lat);
                end
            end
            prev = Rdy;
        end
    end

    // Called at a negedge with Rdy=1; returns at the negedge where Rdy has risen again
    task automatic run_op(input logic [31:0] dd, input logic [15:0] dv,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic ev, input int lat);
        exp_t e;
        int   n;
        e.q = eq; e.r = er; e.v = ev; e.lat = lat; e.e1 = cyc + 1;
        sb.push_back(e);
        St   = 1'b1;
        Dbus = dd[31:16];
        @(negedge CLK);
        check("v_clear_on_start", {31'd0, V}, 32'd0);
        check("rdy_low_busy", {31'd0, Rdy}, 32'd0);
        Dbus = dd[15:0];
        @(negedge CLK);
        St   = 1'b0;
        Dbus = dv;
        @(negedge CLK);
        Dbus = 16'hA5A5;
        n = 0;
        while (!Rdy && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!Rdy) check("rdy_timeout", {31'd0, Rdy}, 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        Rst_n = 1'b0;
        St    = 1'b0;
        Dbus  = 16'h0000;
        #1;
        check("rst_quotient", {16'd0, Quotient}, 32'd0);
        check("rst_remainder", {16'd0, Remainder}, 32'd0);
        check("rst_v", {31'd0, V}, 32'd0);
        check("rst_rdy", {31'd0, Rdy}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        Rst_n = 1'b1;
        @(negedge CLK);

        run_op(32'h0000006F, 16'h0007, 16'h000F, 16'h0006, 1'b0, 21);
        run_op(32'h07FF00BB, 16'hE005, 16'hBFFE, 16'h00C5, 1'b0, 21);
        run_op(32'h3FFF8000, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1, 4);
        run_op(32'hFFFFFE08, 16'h001E, 16'hFFF0, 16'hFFE8, 1'b0, 21);
        run_op(32'hFF80030A, 16'hEFFA, 16'h07FC, 16'hF2F2, 1'b0, 21);
        run_op(32'hC0008000, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1, 4);
        run_op(32'h3FFF7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFE, 1'b0, 21);
        run_op(32'hC0008000, 16'h8000, 16'h7FFF, 16'h0000, 1'b0, 21);
        run_op(32'hFFFFFFFF, 16'h0000, 16'h0002, 16'h0000, 1'b1, 4);
        run_op(32'hC0008001, 16'h7FFF, 16'h8001, 16'h8002, 1'b0, 21);
        run_op(32'hFFFFFFFF, 16'h7FFF, 16'h0000, 16'hFFFF, 1'b0, 21);
        run_op(32'h00000000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 21);

        // Abort an operation mid-divide with an asynchronous reset
        St   = 1'b1;
        Dbus = 16'h0000;
        @(negedge CLK);
        St   = 1'b0;
        Dbus = 16'h006F;
        @(negedge CLK);
        Dbus = 16'h0007;
        repeat (8) @(negedge CLK);
        check("busy_before_abort", {31'd0, Rdy}, 32'd0);
        #2 Rst_n = 1'b0;
        #1;
        check("abort_quotient", {16'd0, Quotient}, 32'd0);
        check("abort_remainder", {16'd0, Remainder}, 32'd0);
        check("abort_v", {31'd0, V}, 32'd0);
        check("abort_rdy", {31'd0, Rdy}, 32'd1);
        @(negedge CLK);
        #2 Rst_n = 1'b1;
        @(negedge CLK);

        run_op(32'h0000006F, 16'h0007, 16'h000F, 16'h0006, 1'b0, 21);

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
